// File: rtl/cr_huf_comp_is_sched_pkg.sv
// Shared types and beat-packing constants for the insertion-sort engine scheduler.
package cr_huf_comp_is_sched_pkg;

   localparam int IS_LANES     = 4;
   localparam int IS_SYM_W     = 8;
   localparam int IS_CNT_W     = 8;
   localparam int IS_BEAT_W    = IS_LANES * (IS_SYM_W + IS_CNT_W);
   localparam int IS_SEQID_W   = 8;
   localparam int IS_BLK_CNT_W = 16;

   typedef enum logic [1:0] {
      IS_SCHED_IDLE,
      IS_SCHED_GRANT,
      IS_SCHED_WAIT_DONE
   } e_is_sched_st;

endpackage

// File: rtl/cr_huf_comp_is_sched_rr_arb2.sv
// Two-way round-robin picker. On a tie the requester that did not win last time is chosen.
module cr_huf_comp_is_sched_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       take,
   output logic       any,
   output logic       pick
);

   logic rr_last;

   always_comb begin
      any  = |req;
      pick = (req == 2'b11) ? ~rr_last : req[1];
   end

   // rr_last resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last <= 1'b1;
      end else if (take && any) begin
         rr_last <= pick;
      end
   end

endmodule

// File: rtl/cr_huf_comp_is_sched.sv
// Block-granular owner of the shared insertion-sort engine: one requester holds it from first beat
// through the engine's done pulse, then the round-robin arbiter picks the next owner.
//
//  state              | meaning
//  IS_SCHED_IDLE      | engine free, arbitrating between pending requesters
//  IS_SCHED_GRANT     | owner's beats muxed straight through to the engine until eob transfers
//  IS_SCHED_WAIT_DONE | block handed over, waiting for the engine's done pulse
module cr_huf_comp_is_sched
   import cr_huf_comp_is_sched_pkg::*;
#(
   parameter int BEAT_W    = IS_BEAT_W,
   parameter int SEQID_W   = IS_SEQID_W,
   parameter int BLK_CNT_W = IS_BLK_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           req0_vld,
   input  logic [BEAT_W-1:0]    req0_dat,
   input  logic [SEQID_W-1:0]   req0_seq_id,
   input  logic                 req0_eob,
   output logic                 req0_rd,
   input  logic [3:0]           req1_vld,
   input  logic [BEAT_W-1:0]    req1_dat,
   input  logic [SEQID_W-1:0]   req1_seq_id,
   input  logic                 req1_eob,
   output logic                 req1_rd,
   output logic [3:0]           eng_vld,
   output logic [BEAT_W-1:0]    eng_dat,
   output logic [SEQID_W-1:0]   eng_seq_id,
   output logic                 eng_eob,
   input  logic                 eng_rd,
   input  logic                 eng_done,
   output logic                 eng_src,
   output logic                 sched_busy,
   output logic [BLK_CNT_W-1:0] blk_cnt0,
   output logic [BLK_CNT_W-1:0] blk_cnt1
);

   e_is_sched_st state, next_st;
   logic         sel;
   logic         arb_any, arb_pick;
   logic         xfer;

   cr_huf_comp_is_sched_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({|req1_vld, |req0_vld}),
      .take  (state == IS_SCHED_IDLE),
      .any   (arb_any),
      .pick  (arb_pick)
   );

   // A read strobe is only passed back when a beat actually moves, so a bubble never pops upstream.
   always_comb begin
      next_st    = state;
      eng_vld    = '0;
      eng_dat    = '0;
      eng_seq_id = '0;
      eng_eob    = 1'b0;
      req0_rd    = 1'b0;
      req1_rd    = 1'b0;
      xfer       = 1'b0;
      case (state)
         IS_SCHED_IDLE: begin
            if (arb_any) next_st = IS_SCHED_GRANT;
         end
         IS_SCHED_GRANT: begin
            if (sel) begin
               eng_vld    = req1_vld;
               eng_dat    = req1_dat;
               eng_seq_id = req1_seq_id;
               eng_eob    = req1_eob;
            end else begin
               eng_vld    = req0_vld;
               eng_dat    = req0_dat;
               eng_seq_id = req0_seq_id;
               eng_eob    = req0_eob;
            end
            xfer    = eng_rd & (|eng_vld);
            req0_rd = xfer & ~sel;
            req1_rd = xfer & sel;
            if (xfer && eng_eob) next_st = IS_SCHED_WAIT_DONE;
         end
         IS_SCHED_WAIT_DONE: begin
            if (eng_done) next_st = IS_SCHED_IDLE;
         end
         default: next_st = IS_SCHED_IDLE;
      endcase
   end

   always_comb begin
      eng_src    = sel;
      sched_busy = (state != IS_SCHED_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IS_SCHED_IDLE;
         sel      <= 1'b0;
         blk_cnt0 <= '0;
         blk_cnt1 <= '0;
      end else begin
         state <= next_st;
         if (state == IS_SCHED_IDLE && arb_any) sel <= arb_pick;
         // Done pulses outside WAIT_DONE are dropped; counters stick at all-ones.
         if (state == IS_SCHED_WAIT_DONE && eng_done) begin
            if (!sel && blk_cnt0 != '1) blk_cnt0 <= blk_cnt0 + 1'b1;
            if (sel && blk_cnt1 != '1)  blk_cnt1 <= blk_cnt1 + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cr_huf_comp_is_sched.sv
// Randomized and directed stimulus for the engine scheduler, checked cycle by cycle against a
// block-level ownership model and the requesters' own beat queues.
module tb_cr_huf_comp_is_sched;

   typedef struct {
      logic [3:0]  vld;
      logic [63:0] dat;
      logic [7:0]  seq;
      logic        eob;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  r_vld [2];
   logic [63:0] r_dat [2];
   logic [7:0]  r_seq [2];
   logic        r_eob [2];
   logic        rd0, rd1;
   logic [3:0]  eng_vld;
   logic [63:0] eng_dat;
   logic [7:0]  eng_seq_id;
   logic        eng_eob, eng_rd, eng_done, eng_src, sched_busy;
   logic [15:0] blk_cnt0, blk_cnt1;

   cr_huf_comp_is_sched dut (
      .clk(clk), .rst_n(rst_n),
      .req0_vld(r_vld[0]), .req0_dat(r_dat[0]), .req0_seq_id(r_seq[0]), .req0_eob(r_eob[0]),
      .req0_rd(rd0),
      .req1_vld(r_vld[1]), .req1_dat(r_dat[1]), .req1_seq_id(r_seq[1]), .req1_eob(r_eob[1]),
      .req1_rd(rd1),
      .eng_vld(eng_vld), .eng_dat(eng_dat), .eng_seq_id(eng_seq_id), .eng_eob(eng_eob),
      .eng_rd(eng_rd), .eng_done(eng_done), .eng_src(eng_src), .sched_busy(sched_busy),
      .blk_cnt0(blk_cnt0), .blk_cnt1(blk_cnt1)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // model: who owns the engine, whether its block is still streaming, last tie winner, counts
   bit          m_busy, m_stream, m_owner, m_rr;
   int unsigned m_cnt [2];
   int          order_q [$];
   beat_t       bq [2][$];
   int          pops [2];
   int          rd_seen [2];
   int          bubble_pct, rd_pct, done_pct, spur_pct;
   logic        rd_obs [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add_block(input int idx, input int len, input logic [7:0] seq);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.vld = 4'($urandom_range(15, 1));
         b.dat = {$urandom, $urandom};
         b.seq = seq;
         b.eob = (i == len - 1);
         bq[idx].push_back(b);
      end
   endtask

   task automatic present();
      for (int i = 0; i < 2; i++) begin
         if (bq[i].size() > 0 && $urandom_range(99) >= bubble_pct) begin
            r_vld[i] = bq[i][0].vld;
            r_dat[i] = bq[i][0].dat;
            r_seq[i] = bq[i][0].seq;
            r_eob[i] = bq[i][0].eob;
         end else begin
            r_vld[i] = 4'h0;
            r_dat[i] = {$urandom, $urandom};
            r_seq[i] = 8'h00;
            r_eob[i] = 1'b0;
         end
      end
      eng_rd   = ($urandom_range(99) < rd_pct);
      eng_done = 1'b0;
      if (m_busy && !m_stream) eng_done = ($urandom_range(99) < done_pct);
      else if (!m_busy)        eng_done = ($urandom_range(99) < spur_pct);
   endtask

   function automatic void model_clear();
      m_busy = 0; m_stream = 0; m_owner = 0; m_rr = 1;
      m_cnt[0] = 0; m_cnt[1] = 0;
      order_q.delete();
      for (int i = 0; i < 2; i++) begin
         bq[i].delete();
         pops[i] = 0;
         rd_seen[i] = 0;
      end
   endfunction

   // Block-level rules: grant on free engine with rr tie-break, stream until eob moves, count on done.
   function automatic void model_edge();
      bit p0, p1;
      p0 = |r_vld[0];
      p1 = |r_vld[1];
      if (!m_busy) begin
         if (p0 || p1) begin
            m_owner  = (p0 && p1) ? !m_rr : p1;
            m_rr     = m_owner;
            m_busy   = 1;
            m_stream = 1;
            order_q.push_back(int'(m_owner));
         end
      end else if (m_stream) begin
         if (eng_rd && (|r_vld[m_owner]) && r_eob[m_owner]) m_stream = 0;
      end else if (eng_done) begin
         if (m_cnt[m_owner] != 32'hFFFF) m_cnt[m_owner]++;
         m_busy = 0;
      end
   endfunction

   task automatic check_outputs();
      logic [3:0] ev;
      logic       erd;
      ev  = m_stream ? r_vld[m_owner] : 4'h0;
      erd = m_stream && eng_rd && (|r_vld[m_owner]);
      chk("busy", 64'(sched_busy), 64'(m_busy));
      chk("src", 64'(eng_src), 64'(m_owner));
      chk("eng_vld", 64'(eng_vld), 64'(ev));
      chk("eng_dat", eng_dat, m_stream ? r_dat[m_owner] : 64'h0);
      chk("eng_seq", 64'(eng_seq_id), m_stream ? 64'(r_seq[m_owner]) : 64'h0);
      chk("eng_eob", 64'(eng_eob), m_stream ? 64'(r_eob[m_owner]) : 64'h0);
      chk("rd0", 64'(rd0), 64'(erd && !m_owner));
      chk("rd1", 64'(rd1), 64'(erd && m_owner));
      chk("blk_cnt0", 64'(blk_cnt0), 64'(m_cnt[0]));
      chk("blk_cnt1", 64'(blk_cnt1), 64'(m_cnt[1]));
   endtask

   task automatic cycle(input bit refill);
      @(negedge clk);
      check_outputs();
      rd_obs[0] = rd0;
      rd_obs[1] = rd1;
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      for (int i = 0; i < 2; i++) begin
         if (rd_obs[i] === 1'b1) begin
            rd_seen[i]++;
            if (bq[i].size() > 0) begin
               void'(bq[i].pop_front());
               pops[i]++;
            end
         end
         if (refill && bq[i].size() == 0 && $urandom_range(99) < 20)
            add_block(i, $urandom_range(4, 1), 8'($urandom));
      end
      present();
   endtask

   task automatic run_until_idle(input string tag, input int max_cyc);
      int n = 0;
      while ((bq[0].size() > 0 || bq[1].size() > 0 || m_busy) && n < max_cyc) begin
         cycle(0);
         n++;
      end
      chk({tag, "_timeout"}, 64'(n >= max_cyc), 64'h0);
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      model_clear();
      present();
      cycle(0);
      cycle(0);
      rst_n = 1'b1;
   endtask

   task automatic knobs(input int b, input int r, input int d, input int s);
      bubble_pct = b; rd_pct = r; done_pct = d; spur_pct = s;
   endtask

   initial begin
      knobs(0, 100, 100, 0);
      model_clear();
      present();
      @(posedge clk);
      do_reset();

      // single requester, 3-beat block
      add_block(0, 3, 8'd5);
      present();
      run_until_idle("t1", 40);
      chk("t1_cnt0", 64'(blk_cnt0), 64'd1);
      chk("t1_cnt1", 64'(blk_cnt1), 64'd0);
      chk("t1_beats", 64'(pops[0]), 64'd3);

      // both pending: strict alternation starting with requester 0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         add_block(0, 2, 8'(i));
         add_block(1, 3, 8'(8 + i));
      end
      present();
      run_until_idle("t2", 200);
      chk("t2_grants", 64'(order_q.size()), 64'd8);
      for (int i = 0; i < 8 && i < order_q.size(); i++)
         chk("t2_order", 64'(order_q[i]), 64'(i % 2));
      chk("t2_cnt0", 64'(blk_cnt0), 64'd4);
      chk("t2_cnt1", 64'(blk_cnt1), 64'd4);

      // engine stalls: no read strobes while eng_rd is low
      do_reset();
      knobs(0, 0, 100, 0);
      add_block(1, 3, 8'h33);
      present();
      for (int i = 0; i < 12; i++) cycle(0);
      chk("t3_rd_stall", 64'(rd_seen[0] + rd_seen[1]), 64'd0);
      knobs(0, 100, 100, 0);
      run_until_idle("t3", 40);
      chk("t3_beats", 64'(pops[1]), 64'd3);
      chk("t3_rd1", 64'(rd_seen[1]), 64'd3);
      chk("t3_cnt1", 64'(blk_cnt1), 64'd1);

      // single-beat block, spurious done while idle
      do_reset();
      knobs(0, 100, 100, 100);
      for (int i = 0; i < 3; i++) cycle(0);
      add_block(0, 1, 8'h44);
      run_until_idle("t4", 20);
      for (int i = 0; i < 5; i++) cycle(0);
      chk("t4_cnt0", 64'(blk_cnt0), 64'd1);
      chk("t4_cnt1", 64'(blk_cnt1), 64'd0);

      // saturation
      do_reset();
      knobs(0, 100, 100, 0);
      force dut.blk_cnt0 = 16'hFFFF;
      #1;
      release dut.blk_cnt0;
      m_cnt[0] = 32'hFFFF;
      add_block(0, 2, 8'h55);
      run_until_idle("t5", 30);
      chk("t5_sat", 64'(blk_cnt0), 64'hFFFF);

      // reset in the middle of a 4-beat block
      do_reset();
      add_block(0, 4, 8'h66);
      begin
         int n = 0;
         while (pops[0] < 2 && n < 20) begin
            cycle(0);
            n++;
         end
         chk("t6_reach", 64'(pops[0]), 64'd2);
      end
      do_reset();
      chk("t6_idle", 64'(sched_busy), 64'd0);
      add_block(1, 2, 8'h77);
      run_until_idle("t6", 30);
      chk("t6_first", 64'(order_q.size() > 0 ? order_q[0] : -1), 64'd1);
      chk("t6_cnt1", 64'(blk_cnt1), 64'd1);
      chk("t6_cnt0", 64'(blk_cnt0), 64'd0);

      // random traffic: bubbles, stalls, variable done latency, stray done pulses
      do_reset();
      knobs(25, 70, 40, 10);
      for (int i = 0; i < 800; i++) cycle(1);
      knobs(0, 100, 100, 0);
      run_until_idle("rand", 300);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
